seq_det_ctrl: RTL

//  Programmable serial pattern-detection controller. Holds a configurable bit pattern,

---
 rtl/seq_det_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/seq_det_ctrl.sv
// -----------------------------------------------------------------------------
// seq_det_ctrl
// Programmable serial pattern-detection controller. A host writes a pattern,
// its length, a match-count target, an overlap mode and a no-match timeout,
// then pulses start. While armed, every qualified serial bit is shifted in and
// compared against the low 'len' bits of the pattern. The run finishes when the
// match count reaches the target, when the timeout expires, or on abort.
//
// Ports
//   clk, rst_n    clock (rising edge) and asynchronous active-low reset
//   cfg_we        config write strobe, honoured in IDLE/DONE only
//   cfg_pattern   pattern, bit [len-1] is the first bit received
//   cfg_len       pattern length, 0 or > PAT_W means PAT_W
//   cfg_target    matches that end the run, 0 = unlimited
//   cfg_overlap   1 = overlapping matches allowed
//   cfg_timeout   max armed cycles without a match, 0 = disabled
//   start, abort  run control
//   din, din_valid serial data and its qualifier
//   busy          high while armed
//   match         one-cycle pulse per detected match
//   match_cnt     matches in this run, saturating
//   done          high while in DONE
//   timeout       run ended by timeout
// -----------------------------------------------------------------------------
module seq_det_ctrl #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int TO_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [4:0]       cfg_len,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             cfg_overlap,
  input  logic [TO_W-1:0]  cfg_timeout,
  input  logic             start,
  input  logic             abort,
  input  logic             din,
  input  logic             din_valid,
  output logic             busy,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             done,
  output logic             timeout
);

  // State bits double as the busy/done outputs, so both come straight from flops.
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ARMED = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  localparam logic [4:0] PAT_W_L = 5'(PAT_W);

  logic [1:0]       state_r;
  logic [PAT_W-1:0] cfg_pattern_r;
  logic [4:0]       cfg_len_r;
  logic [CNT_W-1:0] cfg_target_r;
  logic             cfg_overlap_r;
  logic [TO_W-1:0]  cfg_timeout_r;
  // Only len-1 bits of history are ever needed; the newest bit is din itself.
  logic [PAT_W-2:0] shift_r;
  logic [4:0]       fill_r;
  logic [CNT_W-1:0] match_cnt_r;
  logic             match_r;
  logic             timeout_r;
  logic [TO_W-1:0]  to_cnt_r;

  logic [4:0]       len_eff_s;
  logic [PAT_W-1:0] mask_s;
  logic [PAT_W-1:0] new_shift_s;
  logic [4:0]       fill_inc_s;
  logic             match_det_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             target_hit_s;
  logic [TO_W-1:0]  to_inc_s;
  logic             to_hit_s;

  // Effective pattern length: out-of-range values fall back to the full width.
  always_comb begin
    if ((cfg_len_r == 5'd0) || (cfg_len_r > PAT_W_L)) begin
      len_eff_s = PAT_W_L;
    end else begin
      len_eff_s = cfg_len_r;
    end
  end

  // Compare mask selecting the low len_eff bits.
  always_comb begin
    mask_s = {PAT_W{1'b0}};
    for (int i = 0; i < PAT_W; i++) begin
      mask_s[i] = (5'(i) < len_eff_s);
    end
  end

  // Match detection on the incoming bit plus counter/timeout next values.
  always_comb begin
    new_shift_s  = {shift_r, din};
    fill_inc_s   = fill_r + 5'd1;
    match_det_s  = (state_r == ST_ARMED) && din_valid && !abort &&
                   (fill_inc_s >= len_eff_s) &&
                   ((new_shift_s & mask_s) == (cfg_pattern_r & mask_s));
    if (match_cnt_r == {CNT_W{1'b1}}) begin
      cnt_inc_s = match_cnt_r;
    end else begin
      cnt_inc_s = match_cnt_r + CNT_W'(1);
    end
    target_hit_s = (cfg_target_r != {CNT_W{1'b0}}) && (cnt_inc_s == cfg_target_r);
    to_inc_s     = to_cnt_r + TO_W'(1);
    to_hit_s     = (cfg_timeout_r != {TO_W{1'b0}}) && (to_inc_s >= cfg_timeout_r);
  end

  // Configuration registers, writable only while no run is armed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_pattern_r <= {PAT_W{1'b0}};
      cfg_len_r     <= 5'd0;
      cfg_target_r  <= {CNT_W{1'b0}};
      cfg_overlap_r <= 1'b0;
      cfg_timeout_r <= {TO_W{1'b0}};
    end else if (cfg_we && (state_r != ST_ARMED)) begin
      cfg_pattern_r <= cfg_pattern;
      cfg_len_r     <= cfg_len;
      cfg_target_r  <= cfg_target;
      cfg_overlap_r <= cfg_overlap;
      cfg_timeout_r <= cfg_timeout;
    end
  end

  // Run FSM with shift history, fill, match counter and timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      shift_r     <= {(PAT_W-1){1'b0}};
      fill_r      <= 5'd0;
      match_cnt_r <= {CNT_W{1'b0}};
      match_r     <= 1'b0;
      timeout_r   <= 1'b0;
      to_cnt_r    <= {TO_W{1'b0}};
    end else begin
      match_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_r     <= ST_ARMED;
            shift_r     <= {(PAT_W-1){1'b0}};
            fill_r      <= 5'd0;
            match_cnt_r <= {CNT_W{1'b0}};
            timeout_r   <= 1'b0;
            to_cnt_r    <= {TO_W{1'b0}};
          end
        end
        ST_ARMED: begin
          if (abort) begin
            // The bit sampled in the abort cycle is dropped; count is kept.
            state_r <= ST_IDLE;
          end else begin
            if (din_valid) begin
              shift_r <= new_shift_s[PAT_W-2:0];
              if (match_det_s && !cfg_overlap_r) begin
                fill_r <= 5'd0;
              end else if (fill_r < len_eff_s) begin
                fill_r <= fill_inc_s;
              end
            end
            // A match in the same cycle as an expiring timeout takes priority.
            if (match_det_s) begin
              match_r     <= 1'b1;
              match_cnt_r <= cnt_inc_s;
              to_cnt_r    <= {TO_W{1'b0}};
              if (target_hit_s) begin
                state_r <= ST_DONE;
              end
            end else if (to_hit_s) begin
              state_r   <= ST_DONE;
              timeout_r <= 1'b1;
            end else begin
              to_cnt_r <= to_inc_s;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = state_r[0];
  assign done      = state_r[1];
  assign match     = match_r;
  assign match_cnt = match_cnt_r;
  assign timeout   = timeout_r;

endmodule
